// File: rtl/cla_slice_sequencer.sv
// Sequences a WIDTH-bit add/subtract through one shared, registered 4-bit CLA slice.
// Nibbles are processed LSB first, and the carry is chained between slices.
module cla_slice_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_cout,
  output logic             resp_ovf,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_cout
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_sum   = '0;
    resp_cout  = 1'b0;
    resp_ovf   = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          // Subtract is A + ~B + 1; the +1 enters as the slice-0 carry.
          a_d      = op_a;
          b_d      = op_sub ? ~op_b : op_b;
          carry_d  = op_sub;
          idx_d    = '0;
          result_d = '0;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        add_a   = a_q[{idx_q, 2'b00} +: 4];
        add_b   = b_q[{idx_q, 2'b00} +: 4];
        add_cin = carry_q;
        state_d = SAMPLE;
      end
      SAMPLE: begin
        // The CLA registered this slice at the end of DRIVE, so add_s/add_cout are valid here.
        add_a   = a_q[{idx_q, 2'b00} +: 4];
        add_b   = b_q[{idx_q, 2'b00} +: 4];
        add_cin = carry_q;
        result_d[{idx_q, 2'b00} +: 4] = add_s;
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = DRIVE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_sum   = result_q;
        resp_cout  = carry_q;
        resp_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result_q[WIDTH-1] != a_q[WIDTH-1]);
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/cla_slice_sequencer.md
# cla_slice_sequencer

Multi-cycle controller that performs WIDTH-bit add/subtract by time-multiplexing one registered 4-bit carry-lookahead adder slice (cla_4bit_with_dff: ports A, B, Cin, clk, S, Cout, one-cycle registered output). It accepts operand requests on a valid/ready port, drives the adder one nibble at a time from LSB to MSB, chains the carry between slices, and returns the assembled result on a valid/ready response port. It sits between the requesting datapath and a single shared CLA instance.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NSLICE = WIDTH/4 (derived, not overridable).

- clk  input  1  rising-edge clock, shared with the CLA instance.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- op_sub  input  1  1 = A − B, 0 = A + B.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_sum  output  WIDTH  result.
- resp_cout  output  1  carry out of MSB slice; for subtract, 1 = no borrow.
- resp_ovf  output  1  two's-complement signed overflow.
- add_a  output  4  to CLA A.
- add_b  output  4  to CLA B.
- add_cin  output  1  to CLA Cin.
- add_s  input  4  from CLA S (registered in the CLA).
- add_cout  input  1  from CLA Cout (registered in the CLA).

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: req_ready=1. On req_valid: latch a_reg=op_a, b_reg=op_sub ? ~op_b : op_b, carry=op_sub, idx=0, clear result register; go DRIVE.
- DRIVE: add_a=a_reg[4*idx+:4], add_b=b_reg[4*idx+:4], add_cin=carry. The CLA captures these at the end of this cycle. Next state: SAMPLE.
- SAMPLE: same add_* values held stable. At the end of the cycle: result[4*idx+:4]=add_s, carry=add_cout. If idx==NSLICE−1, go DONE; otherwise idx+1 and go DRIVE.
- DONE: resp_valid=1, resp_sum=result, resp_cout=carry, resp_ovf = (a_reg[WIDTH−1]==b_reg[WIDTH−1]) && (result[WIDTH−1]!=a_reg[WIDTH−1]). All response outputs are held stable until resp_ready=1, then go IDLE.
- add_a, add_b and add_cin are 0 in IDLE and DONE.
- add_s and add_cout are sampled only at the end of SAMPLE. Stale CLA contents (the CLA has no reset) are never used.
- req_ready=0 in DRIVE, SAMPLE and DONE. A new request is not accepted in the same cycle as a response handshake.
- Input operands are ignored after acceptance. Changes to op_a, op_b or op_sub mid-operation have no effect.

## Timing
- Reset (asynchronous, immediate): state=IDLE, idx=0, carry=0, result=0. Outputs: req_ready=1, resp_valid=0, resp_sum=0, resp_cout=0, resp_ovf=0, add_a=0, add_b=0, add_cin=0.
- Reset asserted mid-operation aborts the operation with no response. The first request after reset deassertion is processed normally.
- Latency: a request accepted at edge E0 produces resp_valid=1 after edge E0+2·NSLICE (8 cycles for WIDTH=16).
- Throughput: at most one operation per 2·NSLICE+2 cycles with resp_ready held at 1. The extra 2 cycles are the DONE cycle and the IDLE cycle.
- Slice k is driven during cycles 2k+1 and 2k+2 after acceptance and captured at edge E0+2k+2.
- A backpressured DONE state holds indefinitely with no change to any output.

## Test plan
- Add 0x1234 + 0x4321, op_sub=0 -> resp_sum=0x5555, cout=0, ovf=0. resp_valid rises exactly 8 cycles after acceptance; add_cin=0 on every slice.
- Add 0xFFFF + 0x0001 -> resp_sum=0x0000, cout=1, ovf=0. The carry must propagate through all four slices; check add_cin=1 on slices 1–3.
- Add 0x7FFF + 0x0001 -> resp_sum=0x8000, cout=0, ovf=1. Subtract 0x8000 − 0x0001 -> resp_sum=0x7FFF, cout=1, ovf=1.
- Subtract 0x0005 − 0x0007 -> resp_sum=0xFFFE, cout=0 (borrow), ovf=0. Check add_cin=1 on slice 0.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE -> resp_valid and resp_sum stable, req_ready=0, a req_valid pulse ignored. Then set resp_ready=1 -> IDLE next cycle, and the following request completes correctly.
- Reset mid-op: assert rst during SAMPLE of slice 2 -> all outputs go to reset values immediately and no resp_valid appears. After release, 0x0F0F + 0x00F1 -> 0x1000.
